// File: rtl/fire_ofm_writer.sv
// Double-buffered collector that serializes each captured ofm vector into a channel-major RAM.
// Optional sticky overflow flag: define FIRE_OFM_WRITER_OVF_EN.
module fire_ofm_writer #(
    parameter int DSP_NO = 128,
    parameter int WIDTH  = 16,
    parameter int WOUT   = 128,
    parameter int ADDR_W = $clog2(DSP_NO*WOUT**2),
    parameter int PIX_W  = $clog2(WOUT*WOUT+1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sample,
    input  logic [WIDTH-1:0]  i_ofm [0:DSP_NO-1],
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [WIDTH-1:0]  o_ram_din,
    output logic              o_ram_feedback,
    output logic              o_done,
    output logic              o_ovf,
    output logic [1:0]        o_state,
    output logic [PIX_W-1:0]  o_pix
);
    localparam int W2   = WOUT*WOUT;
    localparam int CH_W = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;
    localparam logic [ADDR_W-1:0] W2_A = ADDR_W'(W2);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Handshake: i_sample is a one-cycle pulse with i_ofm valid in that cycle; there is no
    // backpressure, a pulse that finds both buffers full is dropped.
    logic [1:0]        r_state;
    logic [CH_W-1:0]   r_ch;
    logic [PIX_W-1:0]  r_pix;
    logic [1:0]        r_v;
    logic              r_fp;
    logic              r_dp;
    logic [WIDTH-1:0]  r_buf0 [0:DSP_NO-1];
    logic [WIDTH-1:0]  r_buf1 [0:DSP_NO-1];
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [WIDTH-1:0]  r_din;

    logic              w_done;
    logic              w_cap;
    logic              w_last;
    logic              w_fin;
    logic [PIX_W-1:0]  w_pix_inc;
    logic              w_cur_ready;
    logic              w_oth_ready;
    logic [1:0]        w_nstate;
    logic              w_emit;
    logic              w_src;
    logic [CH_W-1:0]   w_nch;
    logic [PIX_W-1:0]  w_npix;
    logic [WIDTH-1:0]  w_word;
    logic [1:0]        w_v_nxt;

    assign w_done      = (r_state == S_DONE);
    assign w_cap       = i_sample && !w_done && !r_v[r_fp];
    assign w_last      = (r_state == S_DRAIN) && (r_ch == CH_W'(DSP_NO-1));
    assign w_pix_inc   = r_pix + PIX_W'(1);
    assign w_fin       = w_last && (w_pix_inc == PIX_W'(W2));
    // A vector captured on this very edge counts as ready, so draining starts without a gap.
    assign w_cur_ready = r_v[r_dp]  || (w_cap && (r_fp == r_dp));
    assign w_oth_ready = r_v[~r_dp] || (w_cap && (r_fp != r_dp));

    always_comb begin
        w_nstate = r_state;
        w_emit   = 1'b0;
        w_src    = r_dp;
        w_nch    = r_ch;
        w_npix   = r_pix;
        case (r_state)
            S_IDLE: begin
                if (w_cur_ready) begin
                    w_nstate = S_DRAIN;
                    w_emit   = 1'b1;
                    w_nch    = '0;
                end
            end
            S_DRAIN: begin
                if (!w_last) begin
                    w_emit = 1'b1;
                    w_nch  = r_ch + CH_W'(1);
                end else begin
                    w_npix = w_pix_inc;
                    w_nch  = '0;
                    if (w_fin) begin
                        w_nstate = S_DONE;
                    end else if (w_oth_ready) begin
                        w_emit = 1'b1;
                        w_src  = ~r_dp;
                    end else begin
                        w_nstate = S_IDLE;
                    end
                end
            end
            S_DONE:  w_nstate = S_DONE;
            default: w_nstate = S_IDLE;
        endcase
    end

    always_comb begin
        w_word = w_src ? r_buf1[w_nch] : r_buf0[w_nch];
        if (w_cap && (r_fp == w_src)) begin
            w_word = i_ofm[w_nch];
        end
        w_v_nxt = r_v;
        if (w_last) begin
            w_v_nxt[r_dp] = 1'b0;
        end
        if (w_cap) begin
            w_v_nxt[r_fp] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_cap && !r_fp) begin
            r_buf0 <= i_ofm;
        end
        if (w_cap && r_fp) begin
            r_buf1 <= i_ofm;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_ch    <= '0;
            r_pix   <= '0;
            r_v     <= '0;
            r_fp    <= 1'b0;
            r_dp    <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_din   <= '0;
        end else begin
            r_state <= w_nstate;
            r_ch    <= w_nch;
            r_pix   <= w_npix;
            r_v     <= w_v_nxt;
            r_we    <= w_emit;
            if (w_cap) begin
                r_fp <= ~r_fp;
            end
            if (w_last) begin
                r_dp <= ~r_dp;
            end
            if (w_emit) begin
                r_addr <= ADDR_W'(w_nch) * W2_A + ADDR_W'(w_npix);
                r_din  <= w_word;
            end
        end
    end

`ifdef FIRE_OFM_WRITER_OVF_EN
    logic w_drop;
    logic r_ovf;
    assign w_drop = i_sample && !w_done && (&r_v);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end
        if (!i_rst) begin
            assert (!w_drop) else $error("fire_ofm_writer: sample dropped, both buffers full");
        end
    end

    assign o_ovf = r_ovf;
`else
    assign o_ovf = 1'b0;
`endif

    assign o_ram_we       = r_we;
    assign o_ram_addr     = r_addr;
    assign o_ram_din      = r_din;
    assign o_ram_feedback = i_sample | r_v[0] | r_v[1] | (r_state == S_DRAIN);
    assign o_done         = w_done;
    assign o_state        = r_state;
    assign o_pix          = r_pix;
endmodule

// File: tb/tb_fire_ofm_writer.sv
// Bench for fire_ofm_writer: directed scenarios plus random layers against a timeline model
// of accepted vectors (capture cycle, drain window, expected RAM writes).
module tb_fire_ofm_writer;
    localparam int DSP_NO = 4;
    localparam int WIDTH  = 16;
    localparam int WOUT   = 2;
    localparam int ADDR_W = 4;
    localparam int PIX_W  = 3;
    localparam int NPIX   = WOUT*WOUT;
`ifdef FIRE_OFM_WRITER_OVF_EN
    localparam bit OVF_EXP = 1'b1;
`else
    localparam bit OVF_EXP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              i_rst;
    logic              i_sample;
    logic [WIDTH-1:0]  i_ofm [0:DSP_NO-1];
    logic              o_ram_we;
    logic [ADDR_W-1:0] o_ram_addr;
    logic [WIDTH-1:0]  o_ram_din;
    logic              o_ram_feedback;
    logic              o_done;
    logic              o_ovf;
    logic [1:0]        o_state;
    logic [PIX_W-1:0]  o_pix;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Expected write entries: {cycle[15:0], addr[3:0], data[15:0]}.
    logic [35:0] exp_q[$];
    int          acc_t[$];
    int          acc_e[$];
    int          n_acc = 0;
    int          last_end = 0;
    bit          ovf_m = 1'b0;
    logic [15:0] cov_mask = '0;

    fire_ofm_writer #(
        .DSP_NO(DSP_NO), .WIDTH(WIDTH), .WOUT(WOUT), .ADDR_W(ADDR_W), .PIX_W(PIX_W)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_sample(i_sample), .i_ofm(i_ofm),
        .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr), .o_ram_din(o_ram_din),
        .o_ram_feedback(o_ram_feedback), .o_done(o_done), .o_ovf(o_ovf),
        .o_state(o_state), .o_pix(o_pix)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed time=%0t", $time);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Reference model: a vector is accepted unless two earlier vectors are still buffered;
    // drains run back-to-back, DSP_NO writes each, addr = ch*NPIX + pixel index.
    task automatic model_pulse(input int t, input logic [WIDTH-1:0] vec [0:DSP_NO-1]);
        int pending;
        int s;
        pending = 0;
        if (n_acc >= NPIX) return;
        foreach (acc_e[i]) if (acc_e[i] >= t) pending++;
        if (pending >= 2) begin
            ovf_m = 1'b1;
            return;
        end
        s = (t + 1 > last_end + 1) ? t + 1 : last_end + 1;
        for (int ch = 0; ch < DSP_NO; ch++) begin
            exp_q.push_back({16'(s + ch), 4'(ch*NPIX + n_acc), vec[ch]});
        end
        acc_t.push_back(t);
        acc_e.push_back(s + DSP_NO - 1);
        last_end = s + DSP_NO - 1;
        n_acc++;
    endtask

    task automatic model_reset(input int c);
        logic [35:0] keep[$];
        foreach (exp_q[i]) if (int'(exp_q[i][35:20]) <= c) keep.push_back(exp_q[i]);
        exp_q = keep;
        acc_t.delete();
        acc_e.delete();
        n_acc = 0;
        last_end = 0;
        ovf_m = 1'b0;
    endtask

    function automatic logic exp_fb(input int c);
        foreach (acc_t[i]) if (acc_t[i] < c && c <= acc_e[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Scoreboard: every RAM write must be the next expected entry, in the expected cycle.
    always @(negedge clk) begin : mon
        logic [35:0] e;
        if (o_ram_we === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_write: addr=%0d data=%0h cycle=%0d, expected no write",
                       o_ram_addr, o_ram_din, cyc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("write", {cyc[15:0], o_ram_addr, o_ram_din}, e);
            end
            cov_mask[o_ram_addr] = 1'b1;
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1 i_sample = 1'b0;
        #1;
        chk("feedback", {35'd0, o_ram_feedback}, {35'd0, exp_fb(cyc)});
        chk("done", {35'd0, o_done}, {35'd0, (n_acc == NPIX) && (cyc > last_end)});
        chk("ovf", {35'd0, o_ovf}, {35'd0, OVF_EXP & ovf_m});
    endtask

    task automatic pulse(input logic [WIDTH-1:0] vec [0:DSP_NO-1]);
        i_sample = 1'b1;
        i_ofm = vec;
        model_pulse(cyc, vec);
        #1;
        chk("feedback_pulse", {35'd0, o_ram_feedback}, 36'd1);
    endtask

    task automatic rand_vec(output logic [WIDTH-1:0] vec [0:DSP_NO-1]);
        for (int ch = 0; ch < DSP_NO; ch++) vec[ch] = 16'($urandom);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_sample = 1'b0;
        model_reset(cyc);
        tick();
        i_rst = 1'b0;
        cov_mask = '0;
        chk("rst_we",   {35'd0, o_ram_we}, 36'd0);
        chk("rst_addr", {32'd0, o_ram_addr}, 36'd0);
        chk("rst_din",  {20'd0, o_ram_din}, 36'd0);
        chk("rst_pix",  {33'd0, o_pix}, 36'd0);
        chk("rst_done", {35'd0, o_done}, 36'd0);
        chk("rst_ovf",  {35'd0, o_ovf}, 36'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] v [0:DSP_NO-1];
        int guard;
        i_rst = 1'b1;
        i_sample = 1'b0;
        for (int i = 0; i < DSP_NO; i++) i_ofm[i] = '0;
        do_reset();
        repeat (2) tick();

        // Single vector {1,2,3,4}, then the rest of a full layer at 6-cycle spacing
        v[0] = 16'd1; v[1] = 16'd2; v[2] = 16'd3; v[3] = 16'd4;
        pulse(v);
        repeat (5) tick();
        chk("single_fb_low", {35'd0, o_ram_feedback}, 36'd0);
        tick();
        for (int p = 1; p < NPIX; p++) begin
            rand_vec(v);
            pulse(v);
            repeat (6) tick();
        end
        chk("layer_done", {35'd0, o_done}, 36'd1);
        chk("layer_coverage", {20'd0, cov_mask}, 36'hFFFF);
        rand_vec(v);
        pulse(v);
        repeat (6) tick();

        // Burst of two consecutive pulses
        do_reset();
        rand_vec(v); pulse(v); tick();
        rand_vec(v); pulse(v);
        repeat (10) tick();
        chk("burst_addrs", {20'd0, cov_mask}, 36'h3333);

        // Overflow: third back-to-back pulse is dropped
        do_reset();
        rand_vec(v); pulse(v); tick();
        rand_vec(v); pulse(v); tick();
        rand_vec(v); pulse(v);
        repeat (10) tick();
        chk("ovf_flag", {35'd0, o_ovf}, {35'd0, OVF_EXP});
        chk("ovf_pix", {33'd0, o_pix}, 36'd2);

        // Reset in the middle of a drain, then a fresh vector lands at pixel 0
        do_reset();
        rand_vec(v); pulse(v);
        repeat (2) tick();
        do_reset();
        chk("midrst_fb", {35'd0, o_ram_feedback}, 36'd0);
        rand_vec(v); pulse(v);
        repeat (6) tick();
        chk("midrst_addr0", {35'd0, cov_mask[0]}, 36'd1);

        // Pulse in the last drain cycle of the previous vector
        do_reset();
        rand_vec(v); pulse(v); repeat (4) tick();
        rand_vec(v); pulse(v); repeat (4) tick();
        rand_vec(v); pulse(v); repeat (8) tick();
        chk("simul_pix", {33'd0, o_pix}, 36'd3);

        // Random layers
        repeat (8) begin
            do_reset();
            guard = 0;
            while (n_acc < NPIX && guard < 50) begin
                rand_vec(v);
                pulse(v);
                repeat ($urandom_range(1, 8)) tick();
                guard++;
            end
            guard = 0;
            while (cyc <= last_end + 1 && guard < 40) begin
                tick();
                guard++;
            end
            chk("rand_done", {35'd0, o_done}, 36'd1);
            if ($urandom_range(0, 1) == 1) begin
                rand_vec(v);
                pulse(v);
                repeat (5) tick();
            end
        end

        repeat (3) tick();
        chk("exp_q_empty", 36'(exp_q.size()), 36'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
